// File: rtl/nrisc_pkg.sv
// Shared nRisc definitions: default field layout, bubble opcode and
// parameter sanity helpers used at elaboration time.
package nrisc_pkg;

    localparam int DEF_INSTR_W = 8;
    localparam int DEF_OP_W    = 3;
    localparam int DEF_RA_W    = 3;
    localparam int DEF_RB_W    = 2;
    localparam int DEF_IMM_W   = 8;
    localparam int DEF_DEPTH   = 2;

    typedef enum logic [DEF_OP_W-1:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_AND  = 3'd2,
        OP_OR   = 3'd3,
        OP_LOAD = 3'd4,
        OP_STOR = 3'd5,
        OP_JMP  = 3'd6,
        OP_NOP  = 3'd7
    } opcode_e;

    localparam logic [DEF_OP_W-1:0] DEF_NOP_OP = OP_NOP;

    function automatic bit fields_fit(input int instr_w, input int op_w,
                                      input int ra_w, input int rb_w);
        return instr_w == op_w + ra_w + rb_w;
    endfunction

    function automatic bit imm_fits(input int imm_w, input int instr_w);
        return imm_w >= instr_w;
    endfunction

    function automatic bit depth_ok(input int depth);
        return (depth >= 2) && ((depth & (depth - 1)) == 0);
    endfunction

endpackage

// File: rtl/instr_fifo.sv
// DEPTH x INSTR_W instruction queue; occupancy is tracked by an explicit
// counter so full/empty never depend on pointer equality.
module instr_fifo
    import nrisc_pkg::*;
#(
    parameter int INSTR_W = DEF_INSTR_W,
    parameter int DEPTH   = DEF_DEPTH
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [INSTR_W-1:0]         wr_data,
    output logic [INSTR_W-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [INSTR_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   tail;
    logic [CNT_W-1:0]   count_q;

    logic do_push;
    logic do_pop;

    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = mem[head];

    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
        end else if (flush) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                tail <= (tail == LAST_PTR) ? '0 : tail + PTR_W'(1);
            end
            if (do_pop) begin
                head <= (head == LAST_PTR) ? '0 : head + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (do_pop && !do_push) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

    // Storage needs no reset: stale entries are unreachable once count is 0.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[tail] <= wr_data;
        end
    end

endmodule

// File: rtl/decode_queue_stage.sv
// Fetch/decode pipeline stage: queues fetched instructions and registers
// their decoded fields, emitting NOP bubbles on empty queue or jump.
module decode_queue_stage
    import nrisc_pkg::*;
#(
    parameter int              INSTR_W  = DEF_INSTR_W,
    parameter int              OP_W     = DEF_OP_W,
    parameter int              RA_W     = DEF_RA_W,
    parameter int              RB_W     = DEF_RB_W,
    parameter int              IMM_W    = DEF_IMM_W,
    parameter int              SIGN_EXT = 0,
    parameter int              DEPTH    = DEF_DEPTH,
    parameter logic [OP_W-1:0] NOP_OP   = '1
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [INSTR_W-1:0]     instruction,
    input  logic                   jump,
    input  logic                   stall,
    output logic                   out_valid,
    output logic [OP_W-1:0]        operation,
    output logic [RA_W-1:0]        reg_a,
    output logic [RB_W-1:0]        reg_b,
    output logic [IMM_W-1:0]       immediate,
    output logic [$clog2(DEPTH):0] count
);

    if (!fields_fit(INSTR_W, OP_W, RA_W, RB_W)) begin : g_bad_fields
        $error("decode_queue_stage: INSTR_W must equal OP_W+RA_W+RB_W");
    end
    if (!imm_fits(IMM_W, INSTR_W)) begin : g_bad_imm
        $error("decode_queue_stage: IMM_W must be >= INSTR_W");
    end
    if (!depth_ok(DEPTH)) begin : g_bad_depth
        $error("decode_queue_stage: DEPTH must be a power of two >= 2");
    end

    logic [INSTR_W-1:0] entry;
    logic [IMM_W-1:0]   imm_ext;
    logic               fifo_full;
    logic               fifo_empty;
    logic               push;
    logic               pop;

    assign in_ready = !fifo_full;
    assign push     = in_valid && !fifo_full && !jump;
    assign pop      = !stall && !jump && !fifo_empty;

    instr_fifo #(
        .INSTR_W (INSTR_W),
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (push),
        .pop     (pop),
        .flush   (jump),
        .wr_data (instruction),
        .rd_data (entry),
        .count   (count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Fill first, then overlay the instruction; avoids a zero-width
    // replication when IMM_W == INSTR_W.
    always_comb begin
        imm_ext = (SIGN_EXT != 0) ? {IMM_W{entry[INSTR_W-1]}} : '0;
        imm_ext[INSTR_W-1:0] = entry;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            operation <= NOP_OP;
            reg_a     <= '0;
            reg_b     <= '0;
            immediate <= '0;
        end else if (jump) begin
            out_valid <= 1'b0;
            operation <= NOP_OP;
        end else if (!stall) begin
            if (pop) begin
                out_valid <= 1'b1;
                operation <= entry[INSTR_W-1 -: OP_W];
                reg_a     <= entry[INSTR_W-OP_W-1 -: RA_W];
                reg_b     <= entry[RB_W-1:0];
                immediate <= imm_ext;
            end else begin
                out_valid <= 1'b0;
                operation <= NOP_OP;
            end
        end
    end

endmodule

// File: tb/tb_decode_queue_stage.sv
// Directed bench for decode_queue_stage: vector table on the default
// configuration, plus async-reset and sign-extension sequences.
module tb_decode_queue_stage;

    logic        clock;
    logic        reset_n;

    logic        in_valid;
    logic        in_ready;
    logic [7:0]  instruction;
    logic        jump;
    logic        stall;
    logic        out_valid;
    logic [2:0]  operation;
    logic [2:0]  reg_a;
    logic [1:0]  reg_b;
    logic [7:0]  immediate;
    logic [1:0]  count;

    logic        s_in_valid;
    logic        s_in_ready;
    logic [7:0]  s_instruction;
    logic        s_out_valid;
    logic [2:0]  s_operation;
    logic [2:0]  s_reg_a;
    logic [1:0]  s_reg_b;
    logic [15:0] s_immediate;
    logic [1:0]  s_count;

    int checks = 0;
    int errors = 0;

    decode_queue_stage u_dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .instruction (instruction),
        .jump        (jump),
        .stall       (stall),
        .out_valid   (out_valid),
        .operation   (operation),
        .reg_a       (reg_a),
        .reg_b       (reg_b),
        .immediate   (immediate),
        .count       (count)
    );

    decode_queue_stage #(
        .SIGN_EXT (1),
        .IMM_W    (16)
    ) u_sext (
        .clock       (clock),
        .reset_n     (reset_n),
        .in_valid    (s_in_valid),
        .in_ready    (s_in_ready),
        .instruction (s_instruction),
        .jump        (1'b0),
        .stall       (1'b0),
        .out_valid   (s_out_valid),
        .operation   (s_operation),
        .reg_a       (s_reg_a),
        .reg_b       (s_reg_b),
        .immediate   (s_immediate),
        .count       (s_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic       v;
        logic [7:0] ins;
        logic       j;
        logic       s;
        logic       ov;
        logic [2:0] op;
        logic [2:0] ra;
        logic [1:0] rb;
        logic [7:0] imm;
        logic [1:0] cnt;
        logic       rdy;
    } vec_t;

    localparam int NVEC = 19;
    vec_t vecs [NVEC];

    task automatic chk(input string nm, input int idx,
                       input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %h expected %h", nm, idx, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_all(input string tag, input int idx, input logic ov,
                           input logic [2:0] op, input logic [2:0] ra,
                           input logic [1:0] rb, input logic [7:0] imm,
                           input logic [1:0] cnt, input logic rdy);
        chk({tag, ".out_valid"}, idx, 16'(out_valid), 16'(ov));
        chk({tag, ".operation"}, idx, 16'(operation), 16'(op));
        chk({tag, ".reg_a"},     idx, 16'(reg_a),     16'(ra));
        chk({tag, ".reg_b"},     idx, 16'(reg_b),     16'(rb));
        chk({tag, ".immediate"}, idx, 16'(immediate), 16'(imm));
        chk({tag, ".count"},     idx, 16'(count),     16'(cnt));
        chk({tag, ".in_ready"},  idx, 16'(in_ready),  16'(rdy));
    endtask

    initial begin
        //           v     ins    j     s     ov    op    ra    rb    imm    cnt   rdy
        // basic decode of 101_011_10
        vecs[0]  = '{1'b1, 8'hAE, 1'b0, 1'b0, 1'b0, 3'd7, 3'd0, 2'd0, 8'h00, 2'd1, 1'b1};
        vecs[1]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 3'd5, 3'd3, 2'd2, 8'hAE, 2'd0, 1'b1};
        vecs[2]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd7, 3'd3, 2'd2, 8'hAE, 2'd0, 1'b1};
        // fill under stall, third push refused
        vecs[3]  = '{1'b1, 8'h11, 1'b0, 1'b1, 1'b0, 3'd7, 3'd3, 2'd2, 8'hAE, 2'd1, 1'b1};
        vecs[4]  = '{1'b1, 8'h22, 1'b0, 1'b1, 1'b0, 3'd7, 3'd3, 2'd2, 8'hAE, 2'd2, 1'b0};
        vecs[5]  = '{1'b1, 8'h33, 1'b0, 1'b1, 1'b0, 3'd7, 3'd3, 2'd2, 8'hAE, 2'd2, 1'b0};
        // release: pop 11 (no push, was full), then push 33 + pop 22, then 33
        vecs[6]  = '{1'b1, 8'h33, 1'b0, 1'b0, 1'b1, 3'd0, 3'd4, 2'd1, 8'h11, 2'd1, 1'b1};
        vecs[7]  = '{1'b1, 8'h33, 1'b0, 1'b0, 1'b1, 3'd1, 3'd0, 2'd2, 8'h22, 2'd1, 1'b1};
        vecs[8]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 3'd1, 3'd4, 2'd3, 8'h33, 2'd0, 1'b1};
        // queue 44, 55 then jump with 66 presented
        vecs[9]  = '{1'b1, 8'h44, 1'b0, 1'b1, 1'b1, 3'd1, 3'd4, 2'd3, 8'h33, 2'd1, 1'b1};
        vecs[10] = '{1'b1, 8'h55, 1'b0, 1'b1, 1'b1, 3'd1, 3'd4, 2'd3, 8'h33, 2'd2, 1'b0};
        vecs[11] = '{1'b1, 8'h66, 1'b1, 1'b0, 1'b0, 3'd7, 3'd4, 2'd3, 8'h33, 2'd0, 1'b1};
        vecs[12] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd7, 3'd4, 2'd3, 8'h33, 2'd0, 1'b1};
        // jump during stall, then sustained jump
        vecs[13] = '{1'b1, 8'h77, 1'b0, 1'b1, 1'b0, 3'd7, 3'd4, 2'd3, 8'h33, 2'd1, 1'b1};
        vecs[14] = '{1'b1, 8'h88, 1'b0, 1'b1, 1'b0, 3'd7, 3'd4, 2'd3, 8'h33, 2'd2, 1'b0};
        vecs[15] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 3'd3, 3'd5, 2'd3, 8'h77, 2'd1, 1'b1};
        vecs[16] = '{1'b1, 8'h99, 1'b1, 1'b1, 1'b0, 3'd7, 3'd5, 2'd3, 8'h77, 2'd0, 1'b1};
        vecs[17] = '{1'b1, 8'hAA, 1'b1, 1'b0, 1'b0, 3'd7, 3'd5, 2'd3, 8'h77, 2'd0, 1'b1};
        vecs[18] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd7, 3'd5, 2'd3, 8'h77, 2'd0, 1'b1};

        reset_n       = 1'b0;
        in_valid      = 1'b0;
        instruction   = 8'h00;
        jump          = 1'b0;
        stall         = 1'b0;
        s_in_valid    = 1'b0;
        s_instruction = 8'h00;

        repeat (2) @(posedge clock);
        #1;
        chk_all("reset_held", 0, 1'b0, 3'd7, 3'd0, 2'd0, 8'h00, 2'd0, 1'b1);
        #2 reset_n = 1'b1;
        step();
        chk_all("after_reset", 0, 1'b0, 3'd7, 3'd0, 2'd0, 8'h00, 2'd0, 1'b1);

        for (int i = 0; i < NVEC; i++) begin
            in_valid    = vecs[i].v;
            instruction = vecs[i].ins;
            jump        = vecs[i].j;
            stall       = vecs[i].s;
            step();
            chk_all("vec", i, vecs[i].ov, vecs[i].op, vecs[i].ra, vecs[i].rb,
                    vecs[i].imm, vecs[i].cnt, vecs[i].rdy);
        end

        // async reset between edges with two entries queued
        in_valid = 1'b1; instruction = 8'hC1; stall = 1'b1; jump = 1'b0;
        step();
        instruction = 8'hC2;
        step();
        chk("pre_reset.count", 0, 16'(count), 16'd2);
        in_valid = 1'b0; stall = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk_all("async_reset", 0, 1'b0, 3'd7, 3'd0, 2'd0, 8'h00, 2'd0, 1'b1);
        #2 reset_n = 1'b1;
        in_valid = 1'b1; instruction = 8'h77;
        step();
        in_valid = 1'b0; instruction = 8'h00;
        chk_all("post_reset_push", 0, 1'b0, 3'd7, 3'd0, 2'd0, 8'h00, 2'd1, 1'b1);
        step();
        chk_all("post_reset_pop", 0, 1'b1, 3'd3, 3'd5, 2'd3, 8'h77, 2'd0, 1'b1);

        // sign-extending instance
        s_in_valid = 1'b1; s_instruction = 8'hAE;
        step();
        s_in_valid = 1'b0;
        step();
        chk("sext.out_valid", 0, 16'(s_out_valid), 16'd1);
        chk("sext.immediate", 0, s_immediate, 16'hFFAE);
        chk("sext.operation", 0, 16'(s_operation), 16'd5);
        s_in_valid = 1'b1; s_instruction = 8'h2E;
        step();
        s_in_valid = 1'b0;
        step();
        chk("sext.out_valid", 1, 16'(s_out_valid), 16'd1);
        chk("sext.immediate", 1, s_immediate, 16'h002E);
        chk("sext.operation", 1, 16'(s_operation), 16'd1);
        chk("sext.count", 1, 16'(s_count), 16'd0);
        chk("sext.in_ready", 1, 16'(s_in_ready), 16'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/decode_queue_stage.md
Name: decode_queue_stage

Overview:
- Parametrised successor to the nRisc fetch/decode pipeline register.
- Accepts fetched instructions through a valid/ready handshake into a DEPTH-entry queue.
- Splits each instruction into operation/reg_a/reg_b/immediate fields with configurable widths and immediate extension.
- Supports stall (hold) and jump flush (squash to NOP bubble). Sits between instruction memory and the register file/ALU control.

Parameters:
- INSTR_W, 8, instruction width; must equal OP_W+RA_W+RB_W
- OP_W, 3, opcode field width, bits [INSTR_W-1 -: OP_W]
- RA_W, 3, reg_a field width, the next RA_W bits below the opcode
- RB_W, 2, reg_b field width, bits [RB_W-1:0]
- IMM_W, 8, immediate output width; must be >= INSTR_W
- SIGN_EXT, 0, 0 = zero-extend, 1 = sign-extend the instruction to IMM_W
- DEPTH, 2, queue entries; power of two, >= 2
- NOP_OP, all ones, opcode driven during bubbles

Ports:
- clock  in  1  single clock; all state updates on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  instruction presented
- in_ready  out  1  queue can accept; equals (count < DEPTH), registered-state only
- instruction  in  INSTR_W  fetched instruction
- jump  in  1  flush request (taken branch/jump)
- stall  in  1  downstream hold
- out_valid  out  1  decoded fields hold a real instruction
- operation  out  OP_W  opcode field
- reg_a  out  RA_W  reg_a field
- reg_b  out  RB_W  reg_b field
- immediate  out  IMM_W  whole instruction, extended per SIGN_EXT
- count  out  $clog2(DEPTH)+1  current queue occupancy

Behaviour:
- Reset (async on reset_n low, held while low):
  - count=0, head and tail pointers=0, out_valid=0.
  - operation=NOP_OP; reg_a, reg_b, immediate = 0.
  - in_ready=1 from the first cycle after release.
- Push: occurs when in_valid && in_ready && !jump. Writes to the tail and increments the tail modulo DEPTH.
- Pop: occurs when !stall && !jump && count>0. Loads the head entry into the output registers, sets out_valid=1, and increments the head modulo DEPTH.
- Empty queue, no stall: the next edge drives out_valid=0 and operation=NOP_OP. reg_a, reg_b and immediate hold their previous values.
- Stall (no jump): all output registers hold. Push is still permitted if not full.
- Push and pop on the same edge: count unchanged; both pointers advance.
- Latency: an instruction pushed at edge k appears on the outputs after edge k+1 at the earliest. The queue has no bypass path.
- Full: in_ready=0. A presented instruction is not consumed, and the source must hold it. Count never exceeds DEPTH.
- Jump (highest priority, overrides stall and push):
  - On that edge: count=0, pointers reset, out_valid=0, operation=NOP_OP.
  - Any instruction presented that cycle is dropped, even if in_ready=1.
- Jump asserted for several cycles: the stage keeps emitting bubbles.
- Field extraction is pure slicing of the stored entry. Immediate: {(IMM_W-INSTR_W){SIGN_EXT ? instr[INSTR_W-1] : 0}, instr}.
- Pointer wrap: at DEPTH-1 the pointer wraps to 0. Occupancy is tracked by count, never by pointer equality alone.
- Reset asserted mid-operation: all queued instructions are discarded immediately, regardless of clock.

Decomposition:
- Shared package nrisc_pkg: default field widths, NOP_OP, opcode constants, and elaboration checks for INSTR_W==OP_W+RA_W+RB_W and IMM_W>=INSTR_W.
- One sub-module, instr_fifo: parametrised DEPTH x INSTR_W queue with push, pop, flush, count, full and empty.
- The decode/output register logic stays in decode_queue_stage.

Test Plan:
- Basic decode (defaults): push 8'b101_011_10, no stall.
  -> Two edges later: out_valid=1, operation=5, reg_a=3, reg_b=2, immediate=8'hAE.
- Sign extension (SIGN_EXT=1, IMM_W=16): push 8'hAE -> immediate=16'hFFAE. Push 8'h2E -> immediate=16'h002E.
- Fill and stall (DEPTH=2): stall=1, push 8'h11, 8'h22, 8'h33.
  -> count=2, in_ready=0, 8'h33 held.
  -> Release stall: outputs 8'h11, then 8'h22, then 8'h33 in order. in_ready returns to 1 after the first pop.
- Jump flush: queue holds 8'h44 and 8'h55; assert jump with in_valid=1 and 8'h66.
  -> Next edge: count=0, out_valid=0, operation=3'b111.
  -> 8'h66 is never emitted.
- Jump during stall: stall=1 and jump=1 together -> flush occurs; outputs show the bubble despite stall.
- Async reset mid-stream: drop reset_n between edges with count=2.
  -> Immediately count=0, out_valid=0, operation=NOP_OP.
  -> After release, pushing 8'h77 emits 8'h77 first.
